dense_layer_stream: RTL and testbench
=====================================

// Module: dense_layer_stream
// PURPOSE
//  Parametrised streaming fully-connected layer: accepts one input element per cycle over valid/ready,
//  accumulates bias + sum(x[i]*W[i][j]) for all OUT_SIZE neurons in parallel, then presents the result.
//  Successor to the fixed per-layer dense blocks: sizes, widths, optional ReLU, saturation and flush.
//  Sits between feature extraction / previous layer and the next layer or argmax in the NN pipeline.
// PARAMETERS
//  IN_SIZE   32   input elements per vector (>=1)
//  OUT_SIZE  3    neurons (parallel accumulators)
//  IN_W      40   signed input element width
//  W_W       8    signed weight/bias width
//  ACC_W     48   signed accumulator/output width (>= IN_W+W_W)
//  RELU      0    1: clamp negative outputs to 0 at output stage
// PORTS
//  clk        in   1                 clock, all state on rising edge
//  rst_n      in   1                 asynchronous active-low reset
//  flush      in   1                 sync: abort current vector, return to ACC with idx=0
//  in_valid   in   1                 input element valid
//  in_ready   out  1                 block accepts element
//  in_data    in   IN_W signed       input element x[idx]
//  w_addr     out  $clog2(IN_SIZE)   weight row index (= idx), combinational ROM lookup
//  w_row      in   W_W x OUT_SIZE    signed weights W[w_addr][0..OUT_SIZE-1], valid same cycle
//  bias_vec   in   W_W x OUT_SIZE    signed biases, static during a vector
//  out_valid  out  1                 result vector valid
//  out_ready  in   1                 consumer accepts result
//  out_vec    out  ACC_W x OUT_SIZE  signed result (after optional ReLU)
//  ovf        out  1                 sticky: any accumulator saturated since last result accepted
// BEHAVIOUR
//  Reset: state=ACC, idx=0, acc[*]=0, out_vec[*]=0, out_valid=0, ovf=0; in_ready=1 after reset.
//  FSM: ACC (in_ready=1, out_valid=0) / OUT (in_ready=0, out_valid=1).
//  ACC, accept (in_valid&in_ready): prod[j] = in_data * w_row[j] (full IN_W+W_W bits, signed).
//   idx==0: acc[j] <= sat(bias_vec[j] + prod[j])  (bias added exactly once per vector).
//   idx>0 : acc[j] <= sat(acc[j] + prod[j]).
//   idx==IN_SIZE-1: idx<=0, out_vec[j] <= relu?(sat result), state<=OUT. Else idx<=idx+1.
//   No accept: acc, idx hold.
//  sat(): compute in ACC_W+1 bits, clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; clamping sets ovf.
//  RELU=1: out_vec[j] = (v<0) ? 0 : v; applied only to out_vec, not acc.
//  OUT: out_vec stable while out_valid=1. out_valid&out_ready: state<=ACC, out_valid<=0, ovf<=0
//   (unless clamping in same cycle, impossible as no accept in OUT). Next vector may start next cycle.
//  Latency: result valid cycle after last element accepted; throughput IN_SIZE+1 cycles/vector
//   with out_ready held 1.
//  w_addr = idx combinationally in all states.
//  flush (priority over accept and out handshake): state<=ACC, idx<=0, out_valid<=0, ovf<=0;
//   acc contents irrelevant (overwritten at idx 0); element presented in flush cycle is dropped.
//  rst_n low mid-vector: immediate return to reset values, partial sum discarded.
//  IN_SIZE=1: every accept goes straight to OUT.
// TESTING
//  1 Reset: rst_n low mid-accumulation -> out_valid=0, in_ready=1, out_vec all 0, ovf=0 immediately.
//  2 IN_SIZE=4,OUT_SIZE=2, x={1,2,3,4}, W rows all {1,-1}, bias {5,-5} -> out_vec={15,-15},
//    out_valid exactly 1 cycle after 4th accept; RELU=1 gives {15,0}.
//  3 Backpressure: in_valid toggled 1010.., out_ready low 5 cycles -> same sums, out_vec stable,
//    in_ready=0 throughout OUT.
//  4 Saturation: ACC_W=IN_W+W_W, x=max positive, W=127 every row -> out_vec=2^(ACC_W-1)-1, ovf=1,
//    ovf clears on out handshake.
//  5 Flush after 2 of 4 elements, then 4 fresh elements {1,1,1,1}, W=1, bias 0 -> out_vec=4
//    (no residue from aborted vector).
//  6 Back-to-back: 3 vectors, out_ready=1 -> one result per IN_SIZE+1 cycles, each matching model.

Source files
------------

// File: rtl/dense_layer_stream.sv
// Streaming fully-connected layer: one input element per cycle, OUT_SIZE
// saturating accumulators in parallel, result held until the consumer takes it.
module dense_layer_stream #(
  parameter int unsigned IN_SIZE  = 32,
  parameter int unsigned OUT_SIZE = 3,
  parameter int unsigned IN_W     = 40,
  parameter int unsigned W_W      = 8,
  parameter int unsigned ACC_W    = 48,
  parameter int unsigned RELU     = 0
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             flush,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [IN_W-1:0]                                  in_data,
  output logic [((IN_SIZE > 1) ? $clog2(IN_SIZE) : 1)-1:0] w_addr,
  input  logic [OUT_SIZE*W_W-1:0]                          w_row,
  input  logic [OUT_SIZE*W_W-1:0]                          bias_vec,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [OUT_SIZE*ACC_W-1:0]                        out_vec,
  output logic                                             ovf
);

  localparam int unsigned AW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int unsigned PW = IN_W + W_W;
  localparam int unsigned SW = ACC_W + 1;

  localparam logic [0:0] S_ACC = 1'b0;
  localparam logic [0:0] S_OUT = 1'b1;

  logic [0:0]              r_state;
  logic [0:0]              w_state_nxt;
  logic [AW-1:0]           r_idx;
  logic signed [ACC_W-1:0] r_acc [OUT_SIZE];
  logic [OUT_SIZE*ACC_W-1:0] r_out_vec;
  logic                    r_ovf;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_any_clip;
  logic [OUT_SIZE-1:0]     w_clip;
  logic signed [ACC_W-1:0] w_sat  [OUT_SIZE];
  logic signed [ACC_W-1:0] w_relu [OUT_SIZE];

  assign in_ready   = (r_state == S_ACC);
  assign out_valid  = (r_state == S_OUT);
  assign w_accept   = in_valid & in_ready;
  assign w_last     = (r_idx == AW'(IN_SIZE - 1));
  assign w_any_clip = |w_clip;
  assign w_addr     = r_idx;
  assign out_vec    = r_out_vec;
  assign ovf        = r_ovf;

  // Per-neuron multiply, bias-or-accumulate, saturate and optional ReLU
  always_comb begin
    logic signed [PW-1:0]    w_x;
    logic signed [PW-1:0]    w_w;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_base;
    logic signed [SW-1:0]    w_sum;
    w_x    = '0;
    w_w    = '0;
    w_prod = '0;
    w_base = '0;
    w_sum  = '0;
    w_clip = '0;
    for (int j = 0; j < OUT_SIZE; j++) begin
      w_sat[j]  = '0;
      w_relu[j] = '0;
    end
    for (int j = 0; j < OUT_SIZE; j++) begin
      w_x    = PW'($signed(in_data));
      w_w    = PW'($signed(w_row[j*W_W +: W_W]));
      w_prod = w_x * w_w;
      // Bias enters only on the first element so it is added once per vector
      w_base = (r_idx == '0) ? ACC_W'($signed(bias_vec[j*W_W +: W_W])) : r_acc[j];
      w_sum  = SW'(w_base) + SW'(w_prod);
      if (w_sum[SW-1] != w_sum[SW-2]) begin
        w_clip[j] = 1'b1;
        w_sat[j]  = w_sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        w_sat[j]  = w_sum[ACC_W-1:0];
      end
      w_relu[j] = ((RELU != 0) && w_sat[j][ACC_W-1]) ? '0 : w_sat[j];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ACC;
    else        r_state <= w_state_nxt;
  end

  // Next state: flush wins, otherwise last accept enters OUT and handshake leaves it
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_ACC;
    end else begin
      case (r_state)
        S_ACC:   if (w_accept && w_last) w_state_nxt = S_OUT;
        S_OUT:   if (out_ready)          w_state_nxt = S_ACC;
        default: w_state_nxt = S_ACC;
      endcase
    end
  end

  // Index, accumulators, result register and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_out_vec <= '0;
      r_ovf     <= 1'b0;
      for (int j = 0; j < OUT_SIZE; j++) r_acc[j] <= '0;
    end else if (flush) begin
      r_idx <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      for (int j = 0; j < OUT_SIZE; j++) r_acc[j] <= w_sat[j];
      if (w_any_clip) r_ovf <= 1'b1;
      if (w_last) begin
        r_idx <= '0;
        for (int j = 0; j < OUT_SIZE; j++) r_out_vec[j*ACC_W +: ACC_W] <= w_relu[j];
      end else begin
        r_idx <= AW'(r_idx + 1'b1);
      end
    end else if (out_valid && out_ready) begin
      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dense_layer_stream.sv
// Directed bench for dense_layer_stream: two instances (linear and ReLU)
// driven from the same stimulus and a shared weight ROM.
module tb_dense_layer_stream;

  localparam int unsigned IN_SIZE  = 4;
  localparam int unsigned OUT_SIZE = 2;
  localparam int unsigned IN_W     = 16;
  localparam int unsigned W_W      = 8;
  localparam int unsigned ACC_W    = 24;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic [15:0] bias_vec;
  logic [15:0] rom [4];

  logic        in_ready0, in_ready1;
  logic [1:0]  w_addr0, w_addr1;
  logic [15:0] w_row0, w_row1;
  logic        out_valid0, out_valid1;
  logic [47:0] out_vec0, out_vec1;
  logic        ovf0, ovf1;

  int checks;
  int errors;
  int cyc;
  int last_cyc;

  int vx [3][4] = '{'{1, 2, 3, 4}, '{-10, 0, 5, -2}, '{100, -50, 20, 3}};
  int e0 [3] = '{17, -28, -43};
  int e1 [3] = '{3, 10, -235};
  int r0 [3] = '{17, 0, 0};
  int r1 [3] = '{3, 10, 0};
  int tx [4] = '{2, 0, -1, 7};

  assign w_row0 = rom[w_addr0];
  assign w_row1 = rom[w_addr1];

  dense_layer_stream #(
    .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .RELU(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .w_addr(w_addr0), .w_row(w_row0), .bias_vec(bias_vec),
    .out_valid(out_valid0), .out_ready(out_ready), .out_vec(out_vec0), .ovf(ovf0)
  );

  dense_layer_stream #(
    .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .RELU(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .w_addr(w_addr1), .w_row(w_row1), .bias_vec(bias_vec),
    .out_valid(out_valid1), .out_ready(out_ready), .out_vec(out_vec1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] o0(input int j);
    return 64'($signed(out_vec0[j*ACC_W +: ACC_W]));
  endfunction

  function automatic logic signed [63:0] o1(input int j);
    return 64'($signed(out_vec1[j*ACC_W +: ACC_W]));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int x);
    in_valid = 1'b1;
    in_data  = 16'(x);
    step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_cyc = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    bias_vec = {8'hFB, 8'h05};
    for (int i = 0; i < 4; i++) rom[i] = 16'hFF01;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_in_ready_relu", in_ready1, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_out_vec", 64'(out_vec0), 0);

    // Basic sums, W rows {1,-1}, bias {5,-5}
    put(1); put(2); put(3);
    chk("basic_early_valid", out_valid0, 0);
    put(4);
    in_valid = 1'b0;
    chk("basic_valid", out_valid0, 1);
    chk("basic_in_ready", in_ready0, 0);
    chk("basic_n0", o0(0), 15);
    chk("basic_n1", o0(1), -15);
    chk("basic_relu_valid", out_valid1, 1);
    chk("basic_relu_n0", o1(0), 15);
    chk("basic_relu_n1", o1(1), 0);
    chk("basic_ovf", ovf0, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("basic_drain_valid", out_valid0, 0);
    chk("basic_drain_ready", in_ready0, 1);

    // Asynchronous reset in the middle of a vector
    put(7); put(7);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid0, 0);
    chk("arst_in_ready", in_ready0, 1);
    chk("arst_out_vec", 64'(out_vec0), 0);
    chk("arst_out_vec_relu", 64'(out_vec1), 0);
    chk("arst_ovf", ovf0, 0);
    chk("arst_waddr", w_addr0, 0);
    #1 rst_n = 1'b1;
    step();

    // Gapped input and output backpressure
    for (int k = 0; k < 4; k++) begin
      put(tx[k]);
      if (k < 3) begin
        in_valid = 1'b0;
        in_data  = 16'd99;
        step();
      end
    end
    chk("bp_valid", out_valid0, 1);
    chk("bp_n0", o0(0), 13);
    chk("bp_n1", o0(1), -13);
    chk("bp_relu_n0", o1(0), 13);
    chk("bp_relu_n1", o1(1), 0);
    in_valid = 1'b1;
    in_data  = 16'd100;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_ready", in_ready0, 0);
      chk("bp_hold_valid", out_valid0, 1);
      chk("bp_hold_n0", o0(0), 13);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_drain_valid", out_valid0, 0);

    // Saturation both directions, sticky overflow until handshake
    for (int i = 0; i < 4; i++) rom[i] = 16'h807F;
    bias_vec = 16'h0000;
    put(32767); put(32767); put(32767); put(32767);
    in_valid = 1'b0;
    chk("sat_n0", o0(0), 8388607);
    chk("sat_n1", o0(1), -8388608);
    chk("sat_relu_n0", o1(0), 8388607);
    chk("sat_relu_n1", o1(1), 0);
    chk("sat_ovf", ovf0, 1);
    chk("sat_ovf_relu", ovf1, 1);
    step();
    chk("sat_ovf_sticky", ovf0, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("sat_ovf_clear", ovf0, 0);
    chk("sat_drain_valid", out_valid0, 0);

    // Flush mid-vector, then a fresh vector with no residue
    for (int i = 0; i < 4; i++) rom[i] = 16'h0101;
    put(50); put(50);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd1000;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_waddr", w_addr0, 0);
    chk("flush_in_ready", in_ready0, 1);
    chk("flush_out_valid", out_valid0, 0);
    put(1); put(1); put(1); put(1);
    in_valid = 1'b0;
    chk("flush_valid", out_valid0, 1);
    chk("flush_n0", o0(0), 4);
    chk("flush_n1", o0(1), 4);
    chk("flush_relu_n1", o1(1), 4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_out_drop", out_valid0, 0);
    chk("flush_out_ready", in_ready0, 1);

    // Back-to-back vectors with per-row weights
    rom[0] = 16'hFF01; rom[1] = 16'h0302; rom[2] = 16'h01FD; rom[3] = 16'h0004;
    bias_vec  = {8'hFB, 8'h05};
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 4; k++) put(vx[v][k]);
      chk("b2b_valid", out_valid0, 1);
      chk("b2b_n0", o0(0), e0[v]);
      chk("b2b_n1", o0(1), e1[v]);
      chk("b2b_relu_n0", o1(0), r0[v]);
      chk("b2b_relu_n1", o1(1), r1[v]);
      if (v > 0) chk("b2b_period", cyc - last_cyc, 5);
      last_cyc = cyc;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_end_valid", out_valid0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
